spi_flash_rd: RTL

Hardware sequencer that performs an SPI NOR-flash READ (0x03) by driving the SoC SPI controller's register port the way software would. It sits directly upstream of the SPI controller: it issues register writes and reads, consumes the controller's end-of-transfer interrupt, and streams the returned bytes to a consumer over a valid/ready handshake. It is used for boot-time image copy and other CPU-free flash fetches.

---
 rtl/spi_flash_rd_if.sv | 33 +++
 rtl/spi_flash_rd.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/spi_flash_rd_if.sv
// Request/stream side and SPI-controller register port of the flash read sequencer.
// The slave modport is the sequencer's view; master is the requester/controller side.
interface spi_flash_rd_if;
  logic        req_i;
  logic [23:0] addr_i;
  logic [15:0] len_i;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic [7:0]  byte_o;
  logic        byte_vld_o;
  logic        byte_rdy_i;
  logic [7:0]  spi_waddr_o;
  logic [31:0] spi_wdata_o;
  logic [3:0]  spi_sel_o;
  logic        spi_we_o;
  logic [7:0]  spi_raddr_o;
  logic        spi_rd_o;
  logic [31:0] spi_rdata_i;
  logic        spi_irq_i;

  modport slave (
    input  req_i, addr_i, len_i, byte_rdy_i, spi_rdata_i, spi_irq_i,
    output busy_o, done_o, err_o, byte_o, byte_vld_o,
           spi_waddr_o, spi_wdata_o, spi_sel_o, spi_we_o, spi_raddr_o, spi_rd_o
  );

  modport master (
    output req_i, addr_i, len_i, byte_rdy_i, spi_rdata_i, spi_irq_i,
    input  busy_o, done_o, err_o, byte_o, byte_vld_o,
           spi_waddr_o, spi_wdata_o, spi_sel_o, spi_we_o, spi_raddr_o, spi_rd_o
  );
endinterface

// File: rtl/spi_flash_rd.sv
// SPI NOR READ (0x03) sequencer driving the SPI controller register port; first write 1 cycle after accept.
// Consumer backpressure parks the FSM in OUT with CS held and no SPI clocking.
module spi_flash_rd #(
  parameter logic [7:0] DIV   = 8'd0,
  parameter logic       CPOL  = 1'b0,
  parameter logic       CPHA  = 1'b0,
  parameter int         TMO_W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  spi_flash_rd_if.slave  bus
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_CS_ON  = 4'd1;
  localparam logic [3:0] S_LOAD   = 4'd2;
  localparam logic [3:0] S_GO     = 4'd3;
  localparam logic [3:0] S_WAIT   = 4'd4;
  localparam logic [3:0] S_RD     = 4'd5;
  localparam logic [3:0] S_CAP    = 4'd6;
  localparam logic [3:0] S_OUT    = 4'd7;
  localparam logic [3:0] S_CS_OFF = 4'd8;
  localparam logic [3:0] S_FIN    = 4'd9;

  localparam logic [7:0] A_CTRL = 8'h00;
  localparam logic [7:0] A_DATA = 8'h04;
  // Counter value whose increment would reach all-ones: the last WAIT cycle.
  localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

  logic [3:0]       state_q, state_d;
  logic [23:0]      addr_q, addr_d;
  logic [15:0]      rem_q, rem_d;
  logic [2:0]       idx_q, idx_d;
  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [7:0]       byte_q, byte_d;

  logic             we, rd;
  logic [7:0]       waddr, raddr, tx;
  logic [31:0]      wdata;
  logic [3:0]       sel;
  logic             unused_rdata;

  assign unused_rdata = ^bus.spi_rdata_i[31:8];

  function automatic logic [31:0] ctrl_word(input logic cs, input logic start);
    return {16'h0, DIV, 3'b0, 1'b1, cs, CPHA, CPOL, start};
  endfunction

  always_comb begin
    case (idx_q)
      3'd0:    tx = 8'h03;
      3'd1:    tx = addr_q[23:16];
      3'd2:    tx = addr_q[15:8];
      3'd3:    tx = addr_q[7:0];
      default: tx = 8'h00;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    byte_d  = byte_q;
    we      = 1'b0;
    rd      = 1'b0;
    waddr   = 8'h00;
    raddr   = 8'h00;
    wdata   = 32'h0;
    sel     = 4'h0;
    case (state_q)
      S_IDLE: begin
        if (bus.req_i) begin
          addr_d  = bus.addr_i;
          rem_d   = bus.len_i;
          idx_d   = 3'd0;
          err_d   = 1'b0;
          state_d = (bus.len_i == 16'd0) ? S_FIN : S_CS_ON;
        end
      end
      S_CS_ON: begin
        we = 1'b1; waddr = A_CTRL; sel = 4'b0011; wdata = ctrl_word(1'b1, 1'b0);
        state_d = S_LOAD;
      end
      S_LOAD: begin
        we = 1'b1; waddr = A_DATA; sel = 4'b0001; wdata = {24'h0, tx};
        state_d = S_GO;
      end
      S_GO: begin
        we = 1'b1; waddr = A_CTRL; sel = 4'b0011; wdata = ctrl_word(1'b1, 1'b1);
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.spi_irq_i) begin
          // Header RX bytes are discarded; idx saturates at 4 for the data phase.
          if (!idx_q[2]) begin
            idx_d   = idx_q + 3'd1;
            state_d = S_LOAD;
          end else begin
            state_d = S_RD;
          end
        end else if (cnt_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_CS_OFF;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RD: begin
        rd = 1'b1; raddr = A_DATA;
        state_d = S_CAP;
      end
      S_CAP: begin
        byte_d  = bus.spi_rdata_i[7:0];
        state_d = S_OUT;
      end
      S_OUT: begin
        if (bus.byte_rdy_i) begin
          rem_d   = rem_q - 16'd1;
          state_d = (rem_q == 16'd1) ? S_CS_OFF : S_LOAD;
        end
      end
      S_CS_OFF: begin
        we = 1'b1; waddr = A_CTRL; sel = 4'b0011; wdata = ctrl_word(1'b0, 1'b0);
        state_d = S_FIN;
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      byte_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      byte_q  <= byte_d;
    end
  end

  assign bus.busy_o      = (state_q != S_IDLE) && (state_q != S_FIN);
  assign bus.done_o      = (state_q == S_FIN);
  assign bus.err_o       = (state_q == S_FIN) && err_q;
  assign bus.byte_o      = byte_q;
  assign bus.byte_vld_o  = (state_q == S_OUT);
  assign bus.spi_we_o    = we;
  assign bus.spi_waddr_o = waddr;
  assign bus.spi_wdata_o = wdata;
  assign bus.spi_sel_o   = sel;
  assign bus.spi_rd_o    = rd;
  assign bus.spi_raddr_o = raddr;

endmodule
